// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared opcodes, FSM states and datapath select encodings
//
// Purpose: constants shared by the multi-cycle controller and its helpers.
// Ports: none (package).
package multicycle_control_pkg;

  // Recognised major opcodes (IR[6:0]).
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_FSW   = 7'b0100111;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_ADD   = 7'b0110011;
  localparam logic [6:0] OP_RFSOP = 7'b1010011;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_MEMWB,
    S_WB,
    S_BRANCH,
    S_JAL,
    S_FPEXEC,
    S_FPWB,
    S_ILL
  } state_t;

  // alu_op
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  // alu_src_a
  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_RS1   = 2'd1;
  localparam logic [1:0] SRCA_OLDPC = 2'd2;

  // alu_src_b
  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  // reg_src
  localparam logic [1:0] REG_ALUOUT = 2'd0;
  localparam logic [1:0] REG_MDR    = 2'd1;
  localparam logic [1:0] REG_PC     = 2'd2;

  // pc_src
  localparam logic PCSRC_ALU    = 1'b0;
  localparam logic PCSRC_ALUOUT = 1'b1;

  function automatic logic is_store(input logic [6:0] op);
    return (op == OP_SW) || (op == OP_FSW);
  endfunction

endpackage

// File: rtl/multicycle_control_fp_latency_counter.sv
// rtl/multicycle_control_fp_latency_counter.sv - loadable down-counter timing the FP execute phase
//
// Purpose: holds the remaining FP execute cycles.
// Ports: clk, rst (async, active-high); load/load_val set the count;
//        dec decrements (saturating at 0); count and zero report status.
module fp_latency_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle instruction sequencing FSM with memory handshake and FP phase
//
// Purpose: sequences each instruction through fetch/decode/execute/memory/writeback
//          and drives the datapath, memory port and register-file strobes.
// Ports: clk, rst (async, active-high), run (permit new fetch), opcode (IR[6:0]),
//        mem_ready (memory handshake); outputs are memory request controls,
//        IR/PC load enables, ALU/PC/register-source selects, register-file
//        writes, fp_start, illegal and retire strobes.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int FP_LATENCY = 3,
  parameter int ENABLE_FP  = 1,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] reg_src,
  output logic       reg_write,
  output logic       freg_write,
  output logic       fp_start,
  output logic       illegal,
  output logic       retire
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(FP_LATENCY - 1);
  localparam logic             FP_EN  = (ENABLE_FP != 0);

  state_t           state, next;
  logic             fp_load, fp_dec, fp_zero;
  logic [CNT_W-1:0] fp_count;

  fp_latency_counter #(.CNT_W(CNT_W)) u_fp_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (fp_load),
    .load_val (LAT_M1),
    .dec      (fp_dec),
    .count    (fp_count),
    .zero     (fp_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next          = state;
    fp_load       = 1'b0;
    fp_dec        = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PCSRC_ALU;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALU_ADD;
    reg_src       = REG_ALUOUT;
    reg_write     = 1'b0;
    freg_write    = 1'b0;
    fp_start      = 1'b0;
    illegal       = 1'b0;
    retire        = 1'b0;

    case (state)
      S_FETCH: begin
        if (run) begin
          mem_req = 1'b1;
          iord    = 1'b0;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_a = SRCA_PC;
            alu_src_b = SRCB_FOUR;
            pc_src    = PCSRC_ALU;
            next      = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        // Branch/jump target computed speculatively into ALUOut.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW, OP_ADDI, OP_ADD: next = S_EXEC;
          OP_FSW:  next = FP_EN ? S_EXEC : S_ILL;
          OP_BEQ:  next = S_BRANCH;
          OP_JAL:  next = S_JAL;
          OP_RFSOP: begin
            if (FP_EN) begin
              next    = S_FPEXEC;
              fp_load = 1'b1;
            end else begin
              next = S_ILL;
            end
          end
          default: next = S_ILL;
        endcase
      end
      S_EXEC: begin
        alu_src_a = SRCA_RS1;
        if (opcode == OP_ADD) begin
          alu_src_b = SRCB_RS2;
          alu_op    = ALU_FUNCT;
        end else begin
          alu_src_b = SRCB_IMM;
          alu_op    = ALU_ADD;
        end
        next = ((opcode == OP_ADD) || (opcode == OP_ADDI)) ? S_WB : S_MEM;
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        // Depends only on the stable IR opcode, so it cannot glitch while waiting.
        mem_we  = is_store(opcode);
        if (mem_ready) begin
          if (opcode == OP_LW) begin
            next = S_MEMWB;
          end else begin
            retire = 1'b1;
            next   = S_FETCH;
          end
        end
      end
      S_MEMWB: begin
        reg_write = 1'b1;
        reg_src   = REG_MDR;
        retire    = 1'b1;
        next      = S_FETCH;
      end
      S_WB: begin
        reg_write = 1'b1;
        reg_src   = REG_ALUOUT;
        retire    = 1'b1;
        next      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = SRCA_RS1;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PCSRC_ALUOUT;
        retire        = 1'b1;
        next          = S_FETCH;
      end
      S_JAL: begin
        reg_write = 1'b1;
        reg_src   = REG_PC;
        pc_write  = 1'b1;
        pc_src    = PCSRC_ALUOUT;
        retire    = 1'b1;
        next      = S_FETCH;
      end
      S_FPEXEC: begin
        // The counter is loaded on entry and strictly decreases, so it only
        // equals its load value on the first FPEXEC cycle.
        fp_dec   = 1'b1;
        fp_start = (fp_count == LAT_M1);
        if (fp_zero) begin
          next = S_FPWB;
        end
      end
      S_FPWB: begin
        freg_write = 1'b1;
        retire     = 1'b1;
        next       = S_FETCH;
      end
      S_ILL: begin
        illegal = 1'b1;
        retire  = 1'b1;
        next    = S_FETCH;
      end
      default: next = S_FETCH;
    endcase

    if (rst) begin
      fp_load       = 1'b0;
      fp_dec        = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = 1'b0;
      alu_src_a     = 2'd0;
      alu_src_b     = 2'd0;
      alu_op        = 2'd0;
      reg_src       = 2'd0;
      reg_write     = 1'b0;
      freg_write    = 1'b0;
      fp_start      = 1'b0;
      illegal       = 1'b0;
      retire        = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized bench with per-instruction behavioural trace model
module tb_multicycle_control;

  localparam logic [6:0] JAL = 7'b1101111, BEQ = 7'b1100011, LW = 7'b0000011,
                         SW = 7'b0100011, FSW = 7'b0100111, ADDI = 7'b0010011,
                         ADD = 7'b0110011, RFS = 7'b1010011;

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src;
    logic [1:0] alu_src_a, alu_src_b, alu_op, reg_src;
    logic       reg_write, freg_write, fp_start, illegal, retire;
  } ov_t;

  typedef struct packed {
    logic       run;
    logic       rdy;
    logic [6:0] op;
    ov_t        exp;
  } cyc_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       run;
  logic [2:0]       mem_ready;
  logic [2:0][6:0]  opcode;
  logic [2:0][19:0] obs;

  cyc_t q[$];
  ov_t  lg[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Instance 0: FP_LATENCY=3, FP on; 1: FP_LATENCY=1, FP on; 2: FP_LATENCY=2, FP off.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src;
    logic [1:0] alu_src_a, alu_src_b, alu_op, reg_src;
    logic       reg_write, freg_write, fp_start, illegal, retire;

    multicycle_control #(
      .FP_LATENCY (g == 0 ? 3 : (g == 1 ? 1 : 2)),
      .ENABLE_FP  (g == 2 ? 0 : 1),
      .CNT_W      (4)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .run           (run[g]),
      .opcode        (opcode[g]),
      .mem_ready     (mem_ready[g]),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .iord          (iord),
      .ir_write      (ir_write),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .pc_src        (pc_src),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .reg_src       (reg_src),
      .reg_write     (reg_write),
      .freg_write    (freg_write),
      .fp_start      (fp_start),
      .illegal       (illegal),
      .retire        (retire)
    );

    assign obs[g] = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
                     alu_src_a, alu_src_b, alu_op, reg_src,
                     reg_write, freg_write, fp_start, illegal, retire};
  end

  function automatic logic [6:0] rnd7();
    return 7'($urandom);
  endfunction

  task automatic push(input logic r, input logic rd, input logic [6:0] op, input ov_t e);
    cyc_t c;
    c.run = r; c.rdy = rd; c.op = op; c.exp = e;
    q.push_back(c);
  endtask

  // Builds the expected cycle trace of one instruction from its class and the
  // chosen fetch/memory wait counts; run and mem_ready are randomised wherever
  // the instruction must ignore them.
  task automatic gen_instr(input int k, input logic [6:0] op, input int fw, input int mw);
    int   lat;
    bit   en, known, legal;
    ov_t  e;
    lat   = (k == 0) ? 3 : ((k == 1) ? 1 : 2);
    en    = (k != 2);
    known = (op == JAL) || (op == BEQ) || (op == LW) || (op == SW) || (op == FSW) ||
            (op == ADDI) || (op == ADD) || (op == RFS);
    legal = known && (en || ((op != FSW) && (op != RFS)));
    for (int i = 0; i < fw; i++) begin
      e = '0; e.mem_req = 1;
      push(1'b1, 1'b0, rnd7(), e);
    end
    e = '0; e.mem_req = 1; e.ir_write = 1; e.pc_write = 1; e.alu_src_b = 2'd1;
    push(1'b1, 1'b1, rnd7(), e);
    e = '0; e.alu_src_a = 2'd2; e.alu_src_b = 2'd2;
    push(1'($urandom), 1'($urandom), op, e);
    if (!legal) begin
      e = '0; e.illegal = 1; e.retire = 1;
      push(1'($urandom), 1'($urandom), op, e);
    end else if (op == BEQ) begin
      e = '0; e.alu_src_a = 2'd1; e.alu_op = 2'd1; e.pc_write_cond = 1; e.pc_src = 1; e.retire = 1;
      push(1'($urandom), 1'($urandom), op, e);
    end else if (op == JAL) begin
      e = '0; e.reg_write = 1; e.reg_src = 2'd2; e.pc_write = 1; e.pc_src = 1; e.retire = 1;
      push(1'($urandom), 1'($urandom), op, e);
    end else if (op == RFS) begin
      for (int i = 0; i < lat; i++) begin
        e = '0; e.fp_start = (i == 0);
        push(1'($urandom), 1'($urandom), op, e);
      end
      e = '0; e.freg_write = 1; e.retire = 1;
      push(1'($urandom), 1'($urandom), op, e);
    end else begin
      e = '0; e.alu_src_a = 2'd1;
      if (op == ADD) e.alu_op = 2'd2; else e.alu_src_b = 2'd2;
      push(1'($urandom), 1'($urandom), op, e);
      if ((op == ADD) || (op == ADDI)) begin
        e = '0; e.reg_write = 1; e.retire = 1;
        push(1'($urandom), 1'($urandom), op, e);
      end else begin
        for (int i = 0; i <= mw; i++) begin
          e = '0; e.mem_req = 1; e.iord = 1; e.mem_we = (op != LW);
          e.retire = (i == mw) && (op != LW);
          push(1'($urandom), i == mw, op, e);
        end
        if (op == LW) begin
          e = '0; e.reg_write = 1; e.reg_src = 2'd1; e.retire = 1;
          push(1'($urandom), 1'($urandom), op, e);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'($urandom), rnd7(), '0);
  endtask

  // The single compare point: drives each modelled cycle, samples mid-cycle.
  task automatic run_queue(input int k);
    ov_t got;
    lg.delete();
    while (q.size() > 0) begin
      cyc_t c;
      c = q.pop_front();
      @(negedge clk);
      run[k] = c.run; mem_ready[k] = c.rdy; opcode[k] = c.op;
      #2;
      got = ov_t'(obs[k]);
      lg.push_back(got);
      checks++;
      if (got !== c.exp) begin
        errors++;
        $display("FAIL cycle dut%0d t=%0t got=%05h exp=%05h", k, $time, got, c.exp);
      end
    end
  endtask

  task automatic pin(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, expv);
    end
  endtask

  function automatic int count_retire();
    int n = 0;
    foreach (lg[i]) n += lg[i].retire;
    return n;
  endfunction

  initial begin
    ov_t  z;
    cyc_t t;
    int   n;
    logic [6:0] ops[8] = '{JAL, BEQ, LW, SW, FSW, ADDI, ADD, RFS};
    rst = 1'b1; run = '1; mem_ready = '1; opcode = '0;
    #2;
    pin("zero_in_reset", int'(obs[0] | obs[1] | obs[2]), 0);
    @(negedge clk); run = '0;
    @(negedge clk); rst = 1'b0;

    // add with zero-wait memory on instance 0
    gen_instr(0, ADD, 0, 0);
    pin("model_add_len", q.size(), 4);
    run_queue(0);
    pin("add_irwrite_c0", lg[0].ir_write, 1);
    pin("add_aluop_c2", lg[2].alu_op, 2);
    pin("add_regwrite_c3", {lg[3].reg_write, lg[3].reg_src}, 3'b100);
    pin("add_retire_c3", lg[3].retire, 1);
    pin("add_retire_cnt", count_retire(), 1);

    // lw with two memory wait cycles
    gen_instr(0, LW, 0, 2);
    pin("model_lw_len", q.size(), 7);
    run_queue(0);
    n = 0;
    foreach (lg[i]) n += (lg[i].mem_req && lg[i].iord);
    pin("lw_mem_hold", n, 3);
    pin("lw_memwb", {lg[6].reg_write, lg[6].reg_src}, 3'b101);

    // Rfsop at FP_LATENCY=3 then FP_LATENCY=1
    gen_instr(0, RFS, 0, 0);
    pin("model_rfs3_len", q.size(), 6);
    run_queue(0);
    pin("rfs3_fpstart", lg[2].fp_start, 1);
    pin("rfs3_fregw", lg[5].freg_write, 1);
    gen_instr(1, RFS, 0, 0);
    pin("model_rfs1_len", q.size(), 4);
    run_queue(1);
    pin("rfs1_fregw", {lg[2].fp_start, lg[3].freg_write}, 2'b11);

    // FP disabled: both FP opcodes trap
    gen_instr(2, RFS, 0, 0);
    gen_instr(2, FSW, 0, 0);
    pin("model_ill_len", q.size(), 6);
    run_queue(2);
    n = 0;
    foreach (lg[i]) n += lg[i].illegal;
    pin("fpoff_illegal_cnt", n, 2);

    // beq with run dropped after fetch; then idle in FETCH
    gen_instr(0, BEQ, 1, 0);
    for (int i = 2; i < q.size(); i++) begin
      t = q[i]; t.run = 1'b0; q[i] = t;
    end
    idle(3);
    run_queue(0);
    pin("beq_cond", {lg[3].pc_write_cond, lg[3].alu_op}, 3'b101);

    // Reset while sw waits in MEM
    gen_instr(0, SW, 0, 3);
    while (q.size() > 4) void'(q.pop_back());
    run_queue(0);
    pin("sw_mem_we", lg[3].mem_we, 1);
    #1 rst = 1'b1;
    #1 pin("rst_midmem", int'(obs[0]), 0);
    @(negedge clk);
    #1 pin("rst_held", int'(obs[0]), 0);
    run[0] = 1'b0; rst = 1'b0;
    gen_instr(0, SW, 1, 1);
    z = '0; z.mem_req = 1;
    pin("model_fetch_first", int'(q[0].exp), int'(z));
    run_queue(0);

    // Randomised instruction streams on all three configurations
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 30; j++) begin
        if ($urandom_range(0, 9) < 8) gen_instr(k, ops[$urandom_range(0, 7)], $urandom_range(0, 2), $urandom_range(0, 3));
        else gen_instr(k, rnd7(), $urandom_range(0, 2), $urandom_range(0, 3));
        idle($urandom_range(0, 2));
      end
      run_queue(k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
